shift_add_remultiplier: RTL and testbench
=========================================

SHIFT_ADD_REMULTIPLIER -- requirements
Module: shift_add_remultiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, setting the operand width in bits (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request a new computation; sampled on the rising edge of clk.
REQ-005 The block SHALL have port q, input, WIDTH bits: quotient operand, unsigned.
REQ-006 The block SHALL have port d, input, WIDTH bits: divisor operand, unsigned.
REQ-007 The block SHALL have port r, input, WIDTH bits: remainder operand, unsigned.
REQ-008 The block SHALL have port n, output, 2*WIDTH bits: reconstructed dividend, n = q*d + r.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a computation is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse marking n valid.
REQ-011 The block SHALL have port err, output, 1 bit; it exists only when REM_CHECK_EN is defined.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, MUL and DONE.
REQ-013 In IDLE or DONE, start=1 at a clock edge SHALL capture the following, then enter MUL:
- q, d and r into internal registers;
- acc = zero-extended r;
- mcand = zero-extended d;
- cnt = 0.
REQ-014 In MUL, each cycle SHALL perform one iteration, in this order:
- if qreg[0]=1, acc += mcand (2*WIDTH-bit add);
- mcand <<= 1;
- qreg >>= 1;
- cnt += 1.
REQ-015 After exactly WIDTH MUL iterations, the FSM SHALL enter DONE with n = acc.
- done SHALL be high for exactly that one cycle.
- done SHALL therefore assert WIDTH+1 cycles after the edge that samples start.
REQ-016 From DONE, the FSM SHALL return to IDLE on the next edge unless start=1, in which case a new operation SHALL begin per REQ-013.
REQ-017 busy SHALL be 1 exactly while in MUL, and 0 in IDLE and DONE.
REQ-018 start asserted while busy=1 SHALL be ignored, with no effect on state, operands or result.
REQ-019 n SHALL hold its last result until the next DONE; it SHALL NOT change during MUL.
REQ-020 No overflow SHALL occur: the maximum result (2^WIDTH-1)^2 + (2^WIDTH-1) = 2^(2*WIDTH) - 2^WIDTH fits in 2*WIDTH bits.
REQ-021 d=0 SHALL yield n=r; q=0 SHALL yield n=r.
REQ-022 Operand inputs SHALL be don't-care except at the edge where start is accepted.

Reset
REQ-023 rst_n=0 SHALL immediately, without waiting for clk, force:
- state = IDLE;
- n = 0, busy = 0, done = 0, err = 0 (if present);
- all internal registers = 0.
REQ-024 Reset asserted mid-MUL SHALL abort the operation; no done pulse SHALL follow reset release.
REQ-025 After rst_n deasserts, the first start SHALL be accepted on the first rising edge at which it is sampled high.

Configuration
REQ-026 When macro REM_CHECK_EN is defined, the block SHALL compile in the err output and a captured-operand check.
- err SHALL be set in DONE, alongside done, when captured r >= captured d (remainder invalid for division), including d=0.
- err SHALL clear on the next accepted start or on reset.
- n SHALL still be computed normally.
REQ-027 Without REM_CHECK_EN, the err port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification (WIDTH=4)
REQ-028 q=3, d=4, r=2, start pulse -> busy for 4 cycles, done pulse in cycle 5, n=14.
REQ-029 q=15, d=15, r=15 -> n=240 with no overflow; q=0, d=9, r=5 -> n=5; q=9, d=0, r=5 -> n=5.
REQ-030 Start with q=2, d=3, r=1, then start held high with q=7 during MUL -> n=7 (q=7 ignored); next start accepted in the DONE cycle, back-to-back with no IDLE cycle.
REQ-031 rst_n pulsed low in the 2nd MUL cycle -> immediate busy=0 and n=0; no done pulse afterwards; the next start with q=1, d=1, r=0 -> n=1.
REQ-032 REM_CHECK_EN defined:
- q=1, d=3, r=5 -> n=8, err=1;
- next start with q=1, d=3, r=2 -> err cleared at start, n=5, err=0.
REQ-033 REM_CHECK_EN undefined -> build has no err port; scenarios REQ-028 to REQ-031 still pass.

Source files
------------

// File: rtl/shift_add_remultiplier_if.sv
// Operand/result bundle for shift_add_remultiplier.
// The err signal exists only when REM_CHECK_EN is defined.
interface shift_add_remultiplier_if #(
   parameter int WIDTH = 4
);
   logic                 start;
   logic [WIDTH-1:0]     q;
   logic [WIDTH-1:0]     d;
   logic [WIDTH-1:0]     r;
   logic [2*WIDTH-1:0]   n;
   logic                 busy;
   logic                 done;
`ifdef REM_CHECK_EN
   logic                 err;
`endif

   // Requester side: drives the operands, observes the result
   modport master (
      output start, q, d, r,
      input  n, busy, done
`ifdef REM_CHECK_EN
      , input err
`endif
   );

   // Multiplier side
   modport slave (
      input  start, q, d, r,
      output n, busy, done
`ifdef REM_CHECK_EN
      , output err
`endif
   );
endinterface

// File: rtl/shift_add_remultiplier.sv
// Reconstructs a dividend n = q*d + r with a radix-2 shift-and-add
// multiplier: the accumulator is seeded with r and one partial product
// of q*d is added per cycle, so a result takes WIDTH cycles in MUL.
// Optional feature macro: REM_CHECK_EN adds the err output, flagging a
// captured remainder that is not smaller than the captured divisor.
module shift_add_remultiplier #(
   parameter int WIDTH = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   shift_add_remultiplier_if.slave     bus
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     qreg_q, qreg_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   n_q, n_d;
   logic                 busy_o;
   logic                 done_o;
   logic                 accept;
   logic                 last_iter;

   // A start is honoured only outside MUL; it is dropped while busy
   assign accept    = bus.start && (state_q != MUL);
   assign last_iter = (state_q == MUL) && (cnt_q == LAST_CNT);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = MUL;
         MUL:     if (cnt_q == LAST_CNT) state_d = DONE;
         DONE:    state_d = bus.start ? MUL : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded straight from the state register
   always_comb begin
      busy_o = 1'b0;
      done_o = 1'b0;
      case (state_q)
         MUL:     busy_o = 1'b1;
         DONE:    done_o = 1'b1;
         default: ;
      endcase
   end

   assign bus.busy = busy_o;
   assign bus.done = done_o;
   assign bus.n    = n_q;

   // Datapath: operand capture on accept, one shift-add iteration per MUL cycle
   always_comb begin
      qreg_d  = qreg_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      cnt_d   = cnt_q;
      n_d     = n_q;
      if (accept) begin
         qreg_d  = bus.q;
         acc_d   = {{WIDTH{1'b0}}, bus.r};
         mcand_d = {{WIDTH{1'b0}}, bus.d};
         cnt_d   = '0;
      end else if (state_q == MUL) begin
         acc_d   = qreg_q[0] ? (acc_q + mcand_q) : acc_q;
         mcand_d = mcand_q << 1;
         qreg_d  = qreg_q >> 1;
         cnt_d   = cnt_q + CW'(1);
         // n only moves when the final iteration lands, so it is stable in MUL
         if (last_iter) n_d = acc_d;
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qreg_q  <= '0;
         acc_q   <= '0;
         mcand_q <= '0;
         cnt_q   <= '0;
         n_q     <= '0;
      end else begin
         qreg_q  <= qreg_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         cnt_q   <= cnt_d;
         n_q     <= n_d;
      end
   end

`ifdef REM_CHECK_EN
   logic rem_bad_q, rem_bad_d;
   logic err_q, err_d;

   // The remainder check is evaluated on the captured operands; err is
   // published with done and held until the next accepted start
   always_comb begin
      rem_bad_d = rem_bad_q;
      err_d     = err_q;
      if (accept) begin
         rem_bad_d = (bus.r >= bus.d);
         err_d     = 1'b0;
      end else if (last_iter) begin
         err_d     = rem_bad_q;
      end
   end

   // Remainder-check registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_bad_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         rem_bad_q <= rem_bad_d;
         err_q     <= err_d;
      end
   end

   assign bus.err = err_q;
`endif

endmodule

// File: tb/tb_shift_add_remultiplier.sv
// Directed bench for shift_add_remultiplier at WIDTH=4.
module tb_shift_add_remultiplier;
   localparam int W = 4;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;

   shift_add_remultiplier_if #(.WIDTH(W)) bus ();

   shift_add_remultiplier #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle just after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start with the given operands, then wait (bounded) for done.
   // Returns with the bench sitting in the DONE cycle.
   task automatic run_op(input logic [W-1:0] qv, input logic [W-1:0] dv,
                         input logic [W-1:0] rv, output int lat);
      bus.q = qv; bus.d = dv; bus.r = rv; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      lat = 0;
      while (bus.done !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      if (bus.done !== 1'b1) chk("done_timeout", 32'(bus.done), 32'd1);
   endtask

   int lat;
   int done_seen;

   initial begin
      n_cmp = 0;
      n_bad = 0;
      bus.start = 1'b0;
      bus.q = '0; bus.d = '0; bus.r = '0;
      rst_n = 1'b0;
      #2;
      chk("reset_n", 32'(bus.n), 32'd0);
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_done", 32'(bus.done), 32'd0);
`ifdef REM_CHECK_EN
      chk("reset_err", 32'(bus.err), 32'd0);
`endif
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // 3*4+2: busy four cycles, done in the fifth
      bus.q = 4'd3; bus.d = 4'd4; bus.r = 4'd2; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.q = 4'd0; bus.d = 4'd0; bus.r = 4'd0;
      chk("c1_busy", 32'(bus.busy), 32'd1);
      tick();
      chk("c2_busy", 32'(bus.busy), 32'd1);
      chk("c2_n_stable", 32'(bus.n), 32'd0);
      tick();
      chk("c3_busy", 32'(bus.busy), 32'd1);
      tick();
      chk("c4_busy", 32'(bus.busy), 32'd1);
      chk("c4_done", 32'(bus.done), 32'd0);
      tick();
      chk("c5_done", 32'(bus.done), 32'd1);
      chk("c5_busy", 32'(bus.busy), 32'd0);
      chk("c5_n", 32'(bus.n), 32'd14);
`ifdef REM_CHECK_EN
      chk("c5_err", 32'(bus.err), 32'd0);
`endif
      tick();
      chk("c6_done_pulse", 32'(bus.done), 32'd0);
      chk("c6_n_hold", 32'(bus.n), 32'd14);

      // Maximum operands and zero operands
      run_op(4'd15, 4'd15, 4'd15, lat);
      chk("max_lat", 32'(lat), 32'd4);
      chk("max_n", 32'(bus.n), 32'd240);
`ifdef REM_CHECK_EN
      chk("max_err", 32'(bus.err), 32'd1);
`endif
      tick();
      run_op(4'd0, 4'd9, 4'd5, lat);
      chk("q0_n", 32'(bus.n), 32'd5);
`ifdef REM_CHECK_EN
      chk("q0_err", 32'(bus.err), 32'd0);
`endif
      tick();
      run_op(4'd9, 4'd0, 4'd5, lat);
      chk("d0_n", 32'(bus.n), 32'd5);
`ifdef REM_CHECK_EN
      chk("d0_err", 32'(bus.err), 32'd1);
`endif
      tick();

      // Start held high through MUL with a different q must be ignored
      bus.q = 4'd2; bus.d = 4'd3; bus.r = 4'd1; bus.start = 1'b1;
      tick();
      bus.q = 4'd7;
      tick();
      tick();
      tick();
      chk("hold_busy", 32'(bus.busy), 32'd1);
      tick();
      chk("hold_done", 32'(bus.done), 32'd1);
      chk("hold_n", 32'(bus.n), 32'd7);
      // start still high in DONE: next op begins with no IDLE cycle
      bus.q = 4'd4; bus.d = 4'd5; bus.r = 4'd0;
      tick();
      bus.start = 1'b0;
      chk("b2b_busy", 32'(bus.busy), 32'd1);
      chk("b2b_done", 32'(bus.done), 32'd0);
      lat = 0;
      while (bus.done !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      chk("b2b_lat", 32'(lat), 32'd4);
      chk("b2b_n", 32'(bus.n), 32'd20);
      tick();

      // Reset in the second MUL cycle aborts the operation
      bus.q = 4'd5; bus.d = 4'd5; bus.r = 4'd3; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      chk("abort_busy_pre", 32'(bus.busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_n", 32'(bus.n), 32'd0);
      chk("abort_done", 32'(bus.done), 32'd0);
      tick();
      rst_n = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.done === 1'b1) done_seen++;
      end
      chk("abort_no_done", 32'(done_seen), 32'd0);
      run_op(4'd1, 4'd1, 4'd0, lat);
      chk("post_rst_lat", 32'(lat), 32'd4);
      chk("post_rst_n", 32'(bus.n), 32'd1);
      tick();

`ifdef REM_CHECK_EN
      // Invalid remainder flags err; err holds until the next start clears it
      run_op(4'd1, 4'd3, 4'd5, lat);
      chk("rc1_n", 32'(bus.n), 32'd8);
      chk("rc1_err", 32'(bus.err), 32'd1);
      tick();
      chk("rc1_err_hold", 32'(bus.err), 32'd1);
      bus.q = 4'd1; bus.d = 4'd3; bus.r = 4'd2; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("rc2_err_clr", 32'(bus.err), 32'd0);
      lat = 0;
      while (bus.done !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      chk("rc2_n", 32'(bus.n), 32'd5);
      chk("rc2_err", 32'(bus.err), 32'd0);
      tick();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
